// File: rtl/fft_pkg.sv
// Shared constants and types for the 32-point SDF FFT pipeline.
package fft_pkg;

  localparam int FFT_N      = 32;
  localparam int FFT_DATA_W = 16;
  localparam int FFT_OUT_W  = FFT_DATA_W + 1;

  // Feedback delay depth of each radix-2 SDF stage.
  localparam int STAGE1_DELAY = 16;
  localparam int STAGE2_DELAY = 8;
  localparam int STAGE3_DELAY = 4;
  localparam int STAGE4_DELAY = 2;
  localparam int STAGE5_DELAY = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [FFT_OUT_W-1:0] re;
    logic signed [FFT_OUT_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_bf2.sv
// Combinational radix-2 butterfly: sum and difference of two complex operands.
module fft_bf2 #(
  parameter int W = 17
) (
  input  logic [W-1:0] a_r_i,
  input  logic [W-1:0] a_i_i,
  input  logic [W-1:0] b_r_i,
  input  logic [W-1:0] b_i_i,
  output logic [W-1:0] sum_r_o,
  output logic [W-1:0] sum_i_o,
  output logic [W-1:0] diff_r_o,
  output logic [W-1:0] diff_i_o
);

  assign sum_r_o  = a_r_i + b_r_i;
  assign sum_i_o  = a_i_i + b_i_i;
  assign diff_r_o = a_r_i - b_r_i;
  assign diff_i_o = a_i_i - b_i_i;

endmodule

// File: rtl/fft_stage4.sv
// Stage 4 of the 32-point SDF DIF FFT: 2-deep feedback delay line, butterfly
// and inline -j rotation; one bit of growth on the outputs.
// Optional build macro FFT_STAGE4_SCALE_EN: outputs arithmetically shifted
// right by one (floor), same width and timing.
module fft_stage4
  import fft_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_in_r,
  input  logic [DATA_W-1:0] data_in_i,
  output logic              valid_o,
  output logic [DATA_W:0]   data_out_r,
  output logic [DATA_W:0]   data_out_i
);

  localparam int OW = DATA_W + 1;

  state_t      state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic        rearm_q, rearm_d;
  logic        shift_en;
  logic        valid_d;
  logic [1:0]  phase;

  logic [OW-1:0] dl_r_q [STAGE4_DELAY];
  logic [OW-1:0] dl_i_q [STAGE4_DELAY];
  logic [OW-1:0] head_r, head_i;
  logic [OW-1:0] x_r, x_i;
  logic [OW-1:0] sum_r, sum_i, diff_r, diff_i;
  logic [OW-1:0] push_r, push_i;
  logic [OW-1:0] emit_r, emit_i;
  logic [OW-1:0] out_r_d, out_i_d;
  logic [OW-1:0] out_r_q, out_i_q;
  logic          valid_q;

  assign phase  = k_q[1:0];
  assign x_r    = {data_in_r[DATA_W-1], data_in_r};
  assign x_i    = {data_in_i[DATA_W-1], data_in_i};
  assign head_r = dl_r_q[STAGE4_DELAY-1];
  assign head_i = dl_i_q[STAGE4_DELAY-1];

  fft_bf2 #(.W(OW)) u_bf2 (
    .a_r_i    (head_r),
    .a_i_i    (head_i),
    .b_r_i    (x_r),
    .b_i_i    (x_i),
    .sum_r_o  (sum_r),
    .sum_i_o  (sum_i),
    .diff_r_o (diff_r),
    .diff_i_o (diff_i)
  );

  // Control state register: frame state, sample index and rearm flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      rearm_q <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rearm_q <= rearm_d;
    end
  end

  // Next-state logic: start on valid_i only once rearmed, 32 samples, 2 flush cycles.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    rearm_d  = rearm_q;
    shift_en = 1'b0;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!valid_i) rearm_d = 1'b0;
        if (!rearm_q && valid_i) begin
          state_d  = RUN;
          k_d      = 5'd1;
          shift_en = 1'b1;
        end
      end
      RUN: begin
        shift_en = 1'b1;
        valid_d  = (k_q >= 5'd2);
        k_d      = k_q + 5'd1;  // wraps to 0 after x31, giving flush phases 0,1
        if (k_q == 5'd31) state_d = FLUSH;
      end
      FLUSH: begin
        shift_en = 1'b1;
        valid_d  = 1'b1;
        k_d      = k_q + 5'd1;
        if (k_q[0]) begin
          state_d = IDLE;
          k_d     = '0;
          rearm_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath select: phases 0/1 emit the stored difference (phase 1 rotated by -j),
  // phases 2/3 emit the butterfly sum and store the difference.
  always_comb begin
    push_r = phase[1] ? diff_r : x_r;
    push_i = phase[1] ? diff_i : x_i;
    if (phase[1]) begin
      emit_r = sum_r;
      emit_i = sum_i;
    end else if (phase[0]) begin
      emit_r = head_i;
      emit_i = '0 - head_r;
    end else begin
      emit_r = head_r;
      emit_i = head_i;
    end
`ifdef FFT_STAGE4_SCALE_EN
    out_r_d = {emit_r[OW-1], emit_r[OW-1:1]};
    out_i_d = {emit_i[OW-1], emit_i[OW-1:1]};
`else
    out_r_d = emit_r;
    out_i_d = emit_i;
`endif
  end

  // Feedback delay line: entry 0 takes the pushed value, later entries shift along.
  genvar gi;
  generate
    for (gi = 0; gi < STAGE4_DELAY; gi++) begin : g_dl
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            dl_r_q[gi] <= '0;
            dl_i_q[gi] <= '0;
          end else if (shift_en) begin
            dl_r_q[gi] <= push_r;
            dl_i_q[gi] <= push_i;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            dl_r_q[gi] <= '0;
            dl_i_q[gi] <= '0;
          end else if (shift_en) begin
            dl_r_q[gi] <= dl_r_q[gi-1];
            dl_i_q[gi] <= dl_i_q[gi-1];
          end
        end
      end
    end
  endgenerate

  // Output registers: load a result on every valid cycle, otherwise hold data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_r_q <= '0;
      out_i_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (valid_d) begin
        out_r_q <= out_r_d;
        out_i_q <= out_i_d;
      end
    end
  end

  assign valid_o    = valid_q;
  assign data_out_r = out_r_q;
  assign data_out_i = out_i_q;

endmodule

// File: tb/tb_fft_stage4.sv
// Self-checking bench for fft_stage4: per-frame reference model, queue scoreboard,
// framing/rearm/abort checks. Honours FFT_STAGE4_SCALE_EN in its model.
module tb_fft_stage4;

  logic               clk;
  logic               rst_n;
  logic               valid_i;
  logic [15:0]        data_in_r;
  logic [15:0]        data_in_i;
  logic               valid_o;
  logic signed [16:0] data_out_r;
  logic signed [16:0] data_out_i;

  fft_stage4 #(.DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .valid_o    (valid_o),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int frame_aborted = 0;

  int fr_r [32];
  int fr_i [32];
  int ex_r [32];
  int ex_i [32];
  int exp_r_q [$];
  int exp_i_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Build one input frame of the given kind and compute its 32 expected outputs.
  task automatic build(input int kind);
    for (int k = 0; k < 32; k++) begin
      fr_r[k] = 0;
      fr_i[k] = 0;
      case (kind)
        0: fr_r[k] = (k == 0) ? 1 : 0;
        1: fr_i[k] = (k == 1) ? 1 : 0;
        2: begin
          if (k == 0) fr_r[k] = 32767;
          if (k == 1) fr_r[k] = -32768;
          if (k == 2) fr_r[k] = -32768;
          if (k == 3) fr_r[k] = 32767;
        end
        3: fr_r[k] = k;
        default: begin
          fr_r[k] = int'($urandom_range(0, 65535)) - 32768;
          fr_i[k] = int'($urandom_range(0, 65535)) - 32768;
        end
      endcase
    end
    for (int g = 0; g < 8; g++) begin
      int b;
      int dr, di;
      b = 4 * g;
      ex_r[b]   = fr_r[b] + fr_r[b+2];
      ex_i[b]   = fr_i[b] + fr_i[b+2];
      ex_r[b+1] = fr_r[b+1] + fr_r[b+3];
      ex_i[b+1] = fr_i[b+1] + fr_i[b+3];
      ex_r[b+2] = fr_r[b] - fr_r[b+2];
      ex_i[b+2] = fr_i[b] - fr_i[b+2];
      dr = fr_r[b+1] - fr_r[b+3];
      di = fr_i[b+1] - fr_i[b+3];
      ex_r[b+3] = di;
      ex_i[b+3] = -dr;
    end
`ifdef FFT_STAGE4_SCALE_EN
    for (int n = 0; n < 32; n++) begin
      ex_r[n] = ex_r[n] >>> 1;
      ex_i[n] = ex_i[n] >>> 1;
    end
`endif
  endtask

  task automatic pin(input string name, input int n, input int er, input int ei);
    checks++;
    if (ex_r[n] != er || ex_i[n] != ei) begin
      errors++;
      $display("FAIL model_%s y%0d actual (%0d,%0d) required (%0d,%0d)", name, n,
               ex_r[n], ex_i[n], er, ei);
    end
  endtask

  task automatic drive(input logic v, input int r, input int i);
    valid_i   = v;
    data_in_r = 16'(r);
    data_in_i = 16'(i);
    @(posedge clk);
    #1;
  endtask

  // Drive one frame (built beforehand); abort_at<32 asserts reset at that sample.
  task automatic run_frame(input int kind, input int abort_at);
    frame_aborted = 0;
    for (int n = 0; n < 32; n++) begin
      exp_r_q.push_back(ex_r[n]);
      exp_i_q.push_back(ex_i[n]);
    end
    for (int k = 0; k < 32; k++) begin
      if (k == abort_at) begin
        frame_aborted = 1;
        rst_n = 1'b0;
        drive(1'b1, fr_r[k], fr_i[k]);
        exp_r_q.delete();
        exp_i_q.delete();
        checks++;
        if (valid_o !== 1'b0) begin
          errors++;
          $display("FAIL abort_valid kind %0d actual %b required 0", kind, valid_o);
        end
        rst_n = 1'b1;
        break;
      end
      drive(1'b1, fr_r[k], fr_i[k]);
      if (k == 0) start_cyc = cyc;
    end
  endtask

  task automatic idle_low(input int n);
    for (int c = 0; c < n; c++) drive(1'b0, 0, 0);
  endtask

  // Scoreboard: every valid output must match the next expected value,
  // each frame's valid burst starts 2 cycles after x0 and lasts 32 cycles.
  logic prev_v = 1'b0;
  int   run_len = 0;
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      if (prev_v == 1'b0) begin
        checks++;
        if (cyc - start_cyc != 2) begin
          errors++;
          $display("FAIL latency actual %0d required 2", cyc - start_cyc);
        end
      end
      if (exp_r_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid cycle %0d actual 1 required 0", cyc);
      end else begin
        int er, ei;
        er = exp_r_q.pop_front();
        ei = exp_i_q.pop_front();
        checks++;
        if (int'(data_out_r) != er || int'(data_out_i) != ei) begin
          errors++;
          $display("FAIL y%0d actual (%0d,%0d) required (%0d,%0d)", run_len,
                   int'(data_out_r), int'(data_out_i), er, ei);
        end
      end
      run_len++;
    end else begin
      if (prev_v && frame_aborted == 0) begin
        checks++;
        if (run_len != 32) begin
          errors++;
          $display("FAIL valid_len actual %0d required 32", run_len);
        end
      end
      run_len = 0;
    end
    prev_v = valid_o;
  end

  initial begin
    rst_n     = 1'b0;
    valid_i   = 1'b0;
    data_in_r = '0;
    data_in_i = '0;
    @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_out_r !== 17'sd0 || data_out_i !== 17'sd0) begin
      errors++;
      $display("FAIL reset actual v=%b (%0d,%0d) required v=0 (0,0)", valid_o,
               data_out_r, data_out_i);
    end
    rst_n = 1'b1;
    idle_low(4);

`ifndef FFT_STAGE4_SCALE_EN
    build(0);
    pin("impulse", 0, 1, 0);
    pin("impulse", 2, 1, 0);
    pin("impulse", 1, 0, 0);
    build(1);
    pin("jx1", 1, 0, 1);
    pin("jx1", 3, 1, 0);
    build(2);
    pin("extreme", 0, -1, 0);
    pin("extreme", 1, -1, 0);
    pin("extreme", 2, 65535, 0);
    pin("extreme", 3, 0, 65535);
    build(3);
    pin("ramp", 8, 18, 0);
    pin("ramp", 9, 20, 0);
    pin("ramp", 10, -2, 0);
    pin("ramp", 11, 0, 2);
`endif

    // Directed frames separated by a short low gap (flush + one idle cycle).
    for (int kind = 0; kind < 4; kind++) begin
      build(kind);
      run_frame(kind, 32);
      idle_low(3);
    end

    // valid_i held high after a frame must not start another frame.
    build(3);
    run_frame(3, 32);
    for (int c = 0; c < 12; c++) drive(1'b1, 0, 0);
    idle_low(1);

    // Rearmed: random frames back to back with the minimum low gap.
    for (int f = 0; f < 6; f++) begin
      build(4);
      run_frame(4, 32);
      idle_low(3);
    end

    // Reset mid-frame at k=10, then a clean frame afterwards.
    build(4);
    run_frame(4, 10);
    idle_low(6);
    build(4);
    run_frame(4, 32);
    idle_low(6);

    checks++;
    if (exp_r_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected actual %0d required 0", exp_r_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
